// File: rtl/axis_sample_packer_if.sv
// Stream bundle for axis_sample_packer: 16-bit sample input and 32-bit packed output.
// The master modport is the packer's view; slave is the environment's.
interface axis_sample_packer_if;
  logic [15:0] S_AXIS_tdata;
  logic        S_AXIS_tvalid;
  logic [31:0] M_AXIS_tdata;
  logic        M_AXIS_tvalid;
  logic        M_AXIS_tready;

  modport master (
    input  S_AXIS_tdata, S_AXIS_tvalid, M_AXIS_tready,
    output M_AXIS_tdata, M_AXIS_tvalid
  );

  modport slave (
    output S_AXIS_tdata, S_AXIS_tvalid, M_AXIS_tready,
    input  M_AXIS_tdata, M_AXIS_tvalid
  );
endinterface

// File: rtl/axis_sample_packer.sv
// Packs pairs of 16-bit samples into 32-bit words and buffers them in a FWFT FIFO.
// Define PACKER_OVERFLOW_COUNT_EN to add the saturating drop_count output.
module axis_sample_packer #(
  parameter int DEPTH = 4
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     enable,
  axis_sample_packer_if.master     axis,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow
`ifdef PACKER_OVERFLOW_COUNT_EN
  ,
  output logic [15:0]              drop_count
`endif
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {PH_LOW, PH_HIGH} phase_t;

  phase_t      phase, phase_nxt;
  logic [15:0] half_q;
  logic [31:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        accept, push, pop, full, empty, wr_en, drop;

  assign accept = enable && axis.S_AXIS_tvalid;

  // Dropping enable returns to the low half, abandoning any latched half-word.
  always_comb begin
    phase_nxt = phase;
    push      = 1'b0;
    if (!enable) begin
      phase_nxt = PH_LOW;
    end else if (accept) begin
      if (phase == PH_LOW) begin
        phase_nxt = PH_HIGH;
      end else begin
        phase_nxt = PH_LOW;
        push      = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) phase <= PH_LOW;
    else          phase <= phase_nxt;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                          half_q <= '0;
    else if (accept && phase == PH_LOW)    half_q <= axis.S_AXIS_tdata;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && axis.M_AXIS_tready;
  // A full FIFO still takes the word when the head leaves on the same edge.
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  assign axis.M_AXIS_tvalid = !empty;
  assign axis.M_AXIS_tdata  = empty ? 32'h0 : mem[rd_ptr[AW-1:0]];
  assign fifo_level         = wr_ptr - rd_ptr;

  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {axis.S_AXIS_tdata, half_q};
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)     overflow <= 1'b0;
    else if (!enable) overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
  end

`ifdef PACKER_OVERFLOW_COUNT_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                           drop_count <= '0;
    else if (!enable)                       drop_count <= '0;
    else if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_axis_sample_packer.sv
// Directed bench for axis_sample_packer (DEPTH=4): per-cycle vector table plus
// hand-written reset-state and mid-stream reset sequences.
module tb_axis_sample_packer;
  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       enable = 1'b0;
  logic [2:0] fifo_level;
  logic       overflow;
`ifdef PACKER_OVERFLOW_COUNT_EN
  logic [15:0] drop_count;
`endif

  int tests = 0;
  int fails = 0;

  axis_sample_packer_if bus ();

  axis_sample_packer #(.DEPTH(4)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .enable     (enable),
    .axis       (bus.master),
    .fifo_level (fifo_level),
    .overflow   (overflow)
`ifdef PACKER_OVERFLOW_COUNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic        en;
    logic        vl;
    logic [15:0] d;
    logic        rdy;
    logic        tv;
    logic [31:0] td;
    logic [2:0]  lvl;
    logic        ov;
    logic [15:0] dc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic en, input logic vl, input logic [15:0] d, input logic rdy,
                     input logic tv, input logic [31:0] td, input logic [2:0] lvl,
                     input logic ov, input logic [15:0] dc);
    vec_t v;
    v.en = en; v.vl = vl; v.d = d; v.rdy = rdy;
    v.tv = tv; v.td = td; v.lvl = lvl; v.ov = ov; v.dc = dc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic vl, input logic [15:0] d, input logic rdy);
    enable            = en;
    bus.S_AXIS_tvalid = vl;
    bus.S_AXIS_tdata  = d;
    bus.M_AXIS_tready = rdy;
  endtask

  initial begin
    //   en vl d        rdy  tv td            lvl ov dc
    // single pair straight through
    add(1, 1, 16'h0001, 1,   0, 32'h0,        0, 0, 0);
    add(1, 1, 16'h0002, 1,   1, 32'h00020001, 1, 0, 0);
    add(1, 0, 16'h0000, 1,   0, 32'h0,        0, 0, 0);
    add(0, 0, 16'h0000, 1,   0, 32'h0,        0, 0, 0);
    // ten samples into a stalled sink: fifth word is dropped
    add(1, 1, 16'h0001, 0,   0, 32'h0,        0, 0, 0);
    add(1, 1, 16'h0002, 0,   1, 32'h00020001, 1, 0, 0);
    add(1, 1, 16'h0003, 0,   1, 32'h00020001, 1, 0, 0);
    add(1, 1, 16'h0004, 0,   1, 32'h00020001, 2, 0, 0);
    add(1, 1, 16'h0005, 0,   1, 32'h00020001, 2, 0, 0);
    add(1, 1, 16'h0006, 0,   1, 32'h00020001, 3, 0, 0);
    add(1, 1, 16'h0007, 0,   1, 32'h00020001, 3, 0, 0);
    add(1, 1, 16'h0008, 0,   1, 32'h00020001, 4, 0, 0);
    add(1, 1, 16'h0009, 0,   1, 32'h00020001, 4, 0, 0);
    add(1, 1, 16'h000A, 0,   1, 32'h00020001, 4, 1, 1);
    add(1, 0, 16'h0000, 0,   1, 32'h00020001, 4, 1, 1);
    // drain: four words on consecutive cycles, overflow sticks
    add(1, 0, 16'h0000, 1,   1, 32'h00040003, 3, 1, 1);
    add(1, 0, 16'h0000, 1,   1, 32'h00060005, 2, 1, 1);
    add(1, 0, 16'h0000, 1,   1, 32'h00080007, 1, 1, 1);
    add(1, 0, 16'h0000, 1,   0, 32'h0,        0, 1, 1);
    add(1, 0, 16'h0000, 1,   0, 32'h0,        0, 1, 1);
    add(0, 0, 16'h0000, 1,   0, 32'h0,        0, 0, 0);
    // half-word discarded by an enable gap
    add(1, 1, 16'h00AA, 1,   0, 32'h0,        0, 0, 0);
    add(0, 1, 16'h0055, 1,   0, 32'h0,        0, 0, 0);
    add(1, 1, 16'h0011, 1,   0, 32'h0,        0, 0, 0);
    add(1, 1, 16'h0022, 1,   1, 32'h00220011, 1, 0, 0);
    add(1, 0, 16'h0000, 1,   0, 32'h0,        0, 0, 0);
    // fill, then push and pop together while full
    add(1, 1, 16'h0010, 0,   0, 32'h0,        0, 0, 0);
    add(1, 1, 16'h0011, 0,   1, 32'h00110010, 1, 0, 0);
    add(1, 1, 16'h0012, 0,   1, 32'h00110010, 1, 0, 0);
    add(1, 1, 16'h0013, 0,   1, 32'h00110010, 2, 0, 0);
    add(1, 1, 16'h0014, 0,   1, 32'h00110010, 2, 0, 0);
    add(1, 1, 16'h0015, 0,   1, 32'h00110010, 3, 0, 0);
    add(1, 1, 16'h0016, 0,   1, 32'h00110010, 3, 0, 0);
    add(1, 1, 16'h0017, 0,   1, 32'h00110010, 4, 0, 0);
    add(1, 1, 16'h0018, 0,   1, 32'h00110010, 4, 0, 0);
    add(1, 1, 16'h0019, 1,   1, 32'h00130012, 4, 0, 0);
    add(1, 0, 16'h0000, 1,   1, 32'h00150014, 3, 0, 0);
    add(1, 0, 16'h0000, 1,   1, 32'h00170016, 2, 0, 0);
    add(1, 0, 16'h0000, 1,   1, 32'h00190018, 1, 0, 0);
    add(1, 0, 16'h0000, 1,   0, 32'h0,        0, 0, 0);

    // reset state, with live-looking inputs held through clock edges
    drive(1, 1, 16'h1234, 1);
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_tvalid", 0, {31'h0, bus.M_AXIS_tvalid}, 32'h0);
    chk("rst_tdata",  0, bus.M_AXIS_tdata, 32'h0);
    chk("rst_level",  0, {29'h0, fifo_level}, 32'h0);
    chk("rst_overflow", 0, {31'h0, overflow}, 32'h0);
    @(negedge aclk);
    drive(0, 0, 16'h0, 1);
    aresetn = 1'b1;

    foreach (vecs[i]) begin
      @(negedge aclk);
      drive(vecs[i].en, vecs[i].vl, vecs[i].d, vecs[i].rdy);
      @(posedge aclk);
      #1;
      chk("tvalid",   i + 1, {31'h0, bus.M_AXIS_tvalid}, {31'h0, vecs[i].tv});
      chk("tdata",    i + 1, bus.M_AXIS_tdata, vecs[i].td);
      chk("level",    i + 1, {29'h0, fifo_level}, {29'h0, vecs[i].lvl});
      chk("overflow", i + 1, {31'h0, overflow}, {31'h0, vecs[i].ov});
`ifdef PACKER_OVERFLOW_COUNT_EN
      chk("drop_count", i + 1, {16'h0, drop_count}, {16'h0, vecs[i].dc});
`endif
    end

    // mid-stream reset: 3 words plus a pending half-word, then async reset
    for (int k = 0; k < 7; k++) begin
      @(negedge aclk);
      drive(1, 1, 16'h0021 + 16'(k), 0);
    end
    @(posedge aclk);
    #1;
    chk("pre_rst_level", 100, {29'h0, fifo_level}, 32'd3);
    @(negedge aclk);
    drive(1, 0, 16'h0, 0);
    #2;
    aresetn = 1'b0;
    #1;
    chk("async_rst_tvalid", 101, {31'h0, bus.M_AXIS_tvalid}, 32'h0);
    chk("async_rst_level",  101, {29'h0, fifo_level}, 32'h0);
    chk("async_rst_tdata",  101, bus.M_AXIS_tdata, 32'h0);
    @(negedge aclk);
    aresetn = 1'b1;
    drive(1, 1, 16'h000A, 0);
    @(posedge aclk);
    #1;
    chk("post_rst_low_half", 102, {31'h0, bus.M_AXIS_tvalid}, 32'h0);
    @(negedge aclk);
    drive(1, 1, 16'h000B, 0);
    @(posedge aclk);
    #1;
    chk("post_rst_tvalid", 103, {31'h0, bus.M_AXIS_tvalid}, 32'h1);
    chk("post_rst_tdata",  103, bus.M_AXIS_tdata, 32'h000B000A);
    chk("post_rst_level",  103, {29'h0, fifo_level}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axis_sample_packer.md
AXIS_SAMPLE_PACKER -- requirements
Module: axis_sample_packer

Interface
REQ-001 Parameter DEPTH, default 4, output FIFO depth in 32-bit words; power of two, 2..16.
REQ-002 aclk  input  1  single clock; all logic rising-edge.
REQ-003 aresetn  input  1  reset, asynchronous assert, active-low.
REQ-004 enable  input  1  packing enable, level-sensitive.
REQ-005 S_AXIS_tdata  input  16  sample from the ADC path.
REQ-006 S_AXIS_tvalid  input  1  sample valid; the block has no tready and never stalls the source.
REQ-007 M_AXIS_tdata  output  32  packed word, toward the RAM writer stream input.
REQ-008 M_AXIS_tvalid  output  1  packed word available.
REQ-009 M_AXIS_tready  input  1  downstream accept.
REQ-010 fifo_level  output  $clog2(DEPTH)+1  words currently held.
REQ-011 overflow  output  1  sticky; a packed word was dropped.

Function
REQ-012 Sample accepted on a cycle with enable=1 and S_AXIS_tvalid=1; otherwise ignored.
REQ-013 Phase bit: first accepted sample of a pair latched into bits 15:0; second into bits 31:16.
REQ-014 On acceptance of the second sample, the word SHALL be pushed in the same cycle; phase returns to 0.
REQ-015 Latency: with FIFO empty, M_AXIS_tvalid=1 and word on M_AXIS_tdata on the cycle after the second sample is accepted.
REQ-016 FIFO: first-word-fall-through, DEPTH entries, wrap-around pointers, one extra bit for full/empty.
REQ-017 Pop when M_AXIS_tvalid=1 and M_AXIS_tready=1; M_AXIS_tdata/M_AXIS_tvalid stable while tvalid=1 and tready=0.
REQ-018 Push allowed when fifo_level<DEPTH, or when fifo_level=DEPTH and a pop occurs in the same cycle.
REQ-019 Push with FIFO full and no pop: word dropped, FIFO unchanged, overflow set to 1.
REQ-020 Simultaneous push and pop: fifo_level unchanged, ordering preserved.
REQ-021 enable falling: phase cleared to 0 and half-word discarded in the same cycle; FIFO contents remain drainable.
REQ-022 enable rising: the next accepted sample is always a low half-word.
REQ-023 overflow clears only on reset, or on the cycle enable is 0.
REQ-024 fifo_level reflects the registered state after each clock edge.

Reset
REQ-025 aresetn=0 SHALL immediately force: pointers 0, fifo_level 0, M_AXIS_tvalid 0, M_AXIS_tdata 0, phase 0, overflow 0.
REQ-026 Reset mid-operation discards the FIFO contents and the half-word; the first sample after release is a low half.
REQ-027 Reset deassertion is taken as synchronous to aclk; no output changes until the first edge after release.

Configuration
REQ-028 Macro PACKER_OVERFLOW_COUNT_EN defined: add output port drop_count [15:0], counting dropped words, saturating at 0xFFFF, cleared with overflow.
REQ-029 Macro undefined: no drop_count port and no counter logic; all other behaviour identical.

Verification
REQ-030 Reset, enable=1, tready=1, samples 0x0001,0x0002 back-to-back -> one cycle later M_AXIS_tdata=0x00020001, tvalid=1 for one cycle.
REQ-031 tready=0, DEPTH=4, 10 contiguous samples 0x0001..0x000A -> words 0x00020001..0x00080007 held, fifo_level=4, 5th word dropped, overflow=1; with the macro, drop_count=1.
REQ-032 Continuing REQ-031: set tready=1 -> exactly 4 words out in order on 4 consecutive cycles, then tvalid=0, fifo_level=0, overflow still 1.
REQ-033 Sample 0x00AA accepted, enable dropped for 1 cycle, then 0x0011,0x0022 -> output 0x00220011 only; 0x00AA never appears.
REQ-034 FIFO full, tready=1 and second sample accepted in the same cycle -> push accepted, fifo_level stays 4, no overflow.
REQ-035 aresetn pulsed low mid-stream with 3 words buffered -> tvalid=0 and fifo_level=0 with no clock edge; the next pair packs from the low half.
